// File: rtl/line_window_v_fp_if.sv
// ---------------------------------------------------------------------------
// line_window_v_fp_if
//   Stream bundle for the vertical fp window generator.
//   Pixel side : data_i / valid_i (raster order, no backpressure).
//   Window side: window_o (WINDOW_HEIGHT x 1 column, index 0 = oldest line),
//                col_o / row_o (centre coordinates), valid_o, drop_o.
//   master : the pixel source / window consumer (drives data_i, valid_i).
//   slave  : the window generator (drives the window side).
// ---------------------------------------------------------------------------
interface line_window_v_fp_if #(
    parameter int EXP_WIDTH     = 5,
    parameter int FRAC_WIDTH    = 10,
    parameter int WINDOW_HEIGHT = 11
);
    localparam int FP_WIDTH_REG = 1 + EXP_WIDTH + FRAC_WIDTH;

    logic [FP_WIDTH_REG-1:0] data_i;
    logic                    valid_i;
    logic [FP_WIDTH_REG-1:0] window_o [WINDOW_HEIGHT][1];
    logic [15:0]             col_o;
    logic [15:0]             row_o;
    logic                    valid_o;
    logic                    drop_o;

    modport master (
        output data_i,
        output valid_i,
        input  window_o,
        input  col_o,
        input  row_o,
        input  valid_o,
        input  drop_o
    );

    modport slave (
        input  data_i,
        input  valid_i,
        output window_o,
        output col_o,
        output row_o,
        output valid_o,
        output drop_o
    );
endinterface

// File: rtl/line_window_v_fp.sv
// ---------------------------------------------------------------------------
// line_window_v_fp
//   Vertical window generator for fp raster streams. Buffers WINDOW_HEIGHT-1
//   lines and, for every accepted pixel, emits the WINDOW_HEIGHT x 1 column
//   ending at that pixel together with the coordinates of its centre sample.
//   Latency is one cycle; outputs hold their last value while valid_o is low.
//
// Ports
//   clk_i        : clock (single domain)
//   rst_i        : synchronous active-high reset
//   bus.data_i   : pixel sample, raster order
//   bus.valid_i  : data_i valid, no backpressure
//   bus.window_o : window column, [0] = top (oldest line)
//   bus.col_o    : centre column
//   bus.row_o    : centre row
//   bus.valid_o  : window valid
//   bus.drop_o   : one-cycle pulse, an input sample was discarded
//
// Build option
//   LINE_WINDOW_V_ZERO_PAD_EN : when defined, top/bottom borders are padded
//   with +0 so that every pixel of the frame receives one window. The bottom
//   HALF lines are produced by a self-timed FLUSH phase after the last pixel
//   of a frame; samples arriving during FLUSH are discarded and flagged on
//   drop_o. When undefined, only fully populated windows are emitted.
// ---------------------------------------------------------------------------
module line_window_v_fp #(
    parameter int EXP_WIDTH     = 5,
    parameter int FRAC_WIDTH    = 10,
    parameter int WINDOW_HEIGHT = 11,
    parameter int IMAGE_WIDTH   = 640,
    parameter int IMAGE_HEIGHT  = 480
) (
    input logic               clk_i,
    input logic               rst_i,
    line_window_v_fp_if.slave bus
);

    localparam int FP_WIDTH_REG = 1 + EXP_WIDTH + FRAC_WIDTH;
    localparam int HALF         = (WINDOW_HEIGHT - 1) / 2;
    localparam int LB_DEPTH     = WINDOW_HEIGHT - 1;
    localparam int COL_W        = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
    localparam int ROW_W        = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;
    localparam logic [FP_WIDTH_REG-1:0] FP_ZERO = {FP_WIDTH_REG{1'b0}};

`ifdef LINE_WINDOW_V_ZERO_PAD_EN
    // With padding a window exists as soon as the centre row is inside the image.
    localparam int FIRST_ROW    = HALF;
    localparam int FROW_W       = (HALF > 1) ? $clog2(HALF) : 1;
    typedef enum logic [0:0] {
        ST_STREAM = 1'b0,
        ST_FLUSH  = 1'b1
    } state_t;
`else
    // Without padding the window must be completely filled with image rows.
    localparam int FIRST_ROW    = WINDOW_HEIGHT - 1;
    typedef enum logic [0:0] {
        ST_STREAM = 1'b0
    } state_t;
`endif

    state_t                  state_r;
    logic [COL_W-1:0]        in_col_r;
    logic [ROW_W-1:0]        in_row_r;
`ifdef LINE_WINDOW_V_ZERO_PAD_EN
    logic [FROW_W-1:0]       flush_row_r;
`endif

    // Line buffers: lb_r[0] holds the most recent line, lb_r[LB_DEPTH-1] the oldest.
    logic [FP_WIDTH_REG-1:0] lb_r [LB_DEPTH][IMAGE_WIDTH];

    logic                    accept_s;
    logic                    flush_s;
    logic                    shift_en_s;
    logic                    last_col_s;
    logic                    last_row_s;
    logic                    emit_s;
    logic [15:0]             emit_row_s;
    logic [FP_WIDTH_REG-1:0] shift_data_s;
    logic [FP_WIDTH_REG-1:0] tap_s [WINDOW_HEIGHT];

    // Per-cycle control: which source feeds the shift chain and counter wrap points.
    always_comb begin
        accept_s = 1'b0;
        flush_s  = 1'b0;
        case (state_r)
            ST_STREAM: accept_s = bus.valid_i;
`ifdef LINE_WINDOW_V_ZERO_PAD_EN
            ST_FLUSH:  flush_s  = 1'b1;
`endif
            default: begin
                accept_s = 1'b0;
                flush_s  = 1'b0;
            end
        endcase
        shift_en_s = accept_s | flush_s;
        // FLUSH pushes +0 through the chain so the bottom border reads as zero.
        if (flush_s) begin
            shift_data_s = FP_ZERO;
        end else begin
            shift_data_s = bus.data_i;
        end
        last_col_s = (in_col_r == COL_W'(IMAGE_WIDTH - 1));
        last_row_s = (in_row_r == ROW_W'(IMAGE_HEIGHT - 1));
    end

    // Window taps: old buffer contents at the current column plus the new sample.
    always_comb begin
        for (int k = 0; k < LB_DEPTH; k++) begin
`ifdef LINE_WINDOW_V_ZERO_PAD_EN
            // Rows above the frame top hold stale data from earlier frames; force +0.
            if (!flush_s && ((32'(in_row_r) + 32'(k)) < 32'(LB_DEPTH))) begin
                tap_s[k] = FP_ZERO;
            end else begin
                tap_s[k] = lb_r[LB_DEPTH-1-k][in_col_r];
            end
`else
            tap_s[k] = lb_r[LB_DEPTH-1-k][in_col_r];
`endif
        end
        tap_s[WINDOW_HEIGHT-1] = shift_data_s;
    end

    // Decide whether this cycle produces a window and which centre row it carries.
    always_comb begin
        emit_s     = 1'b0;
        emit_row_s = 16'(in_row_r) - 16'(HALF);
        if (accept_s && (in_row_r >= ROW_W'(FIRST_ROW))) begin
            emit_s = 1'b1;
        end else begin
            emit_s = 1'b0;
        end
`ifdef LINE_WINDOW_V_ZERO_PAD_EN
        // In FLUSH every cycle is a window; in_row_r is already 0, so rows come
        // from the dedicated flush row counter.
        if (flush_s) begin
            emit_s     = 1'b1;
            emit_row_s = 16'(IMAGE_HEIGHT - HALF) + 16'(flush_row_r);
        end else begin
            emit_row_s = 16'(in_row_r) - 16'(HALF);
        end
`endif
    end

    // Line buffer shift chain; read-before-write at the same column, never reset.
    always_ff @(posedge clk_i) begin
        if (shift_en_s) begin
            for (int j = LB_DEPTH - 1; j > 0; j--) begin
                lb_r[j][in_col_r] <= lb_r[j-1][in_col_r];
            end
            lb_r[0][in_col_r] <= shift_data_s;
        end
    end

    // FSM, raster counters and registered outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r     <= ST_STREAM;
            in_col_r    <= {COL_W{1'b0}};
            in_row_r    <= {ROW_W{1'b0}};
`ifdef LINE_WINDOW_V_ZERO_PAD_EN
            flush_row_r <= {FROW_W{1'b0}};
`endif
            for (int k = 0; k < WINDOW_HEIGHT; k++) begin
                bus.window_o[k][0] <= FP_ZERO;
            end
            bus.col_o   <= 16'd0;
            bus.row_o   <= 16'd0;
            bus.valid_o <= 1'b0;
            bus.drop_o  <= 1'b0;
        end else begin
            bus.valid_o <= emit_s;
`ifdef LINE_WINDOW_V_ZERO_PAD_EN
            bus.drop_o  <= flush_s & bus.valid_i;
`else
            bus.drop_o  <= 1'b0;
`endif
            if (emit_s) begin
                for (int k = 0; k < WINDOW_HEIGHT; k++) begin
                    bus.window_o[k][0] <= tap_s[k];
                end
                bus.col_o <= 16'(in_col_r);
                bus.row_o <= emit_row_s;
            end

            case (state_r)
                ST_STREAM: begin
                    if (accept_s) begin
                        if (last_col_s) begin
                            in_col_r <= {COL_W{1'b0}};
                            if (last_row_s) begin
                                in_row_r <= {ROW_W{1'b0}};
`ifdef LINE_WINDOW_V_ZERO_PAD_EN
                                state_r     <= ST_FLUSH;
                                flush_row_r <= {FROW_W{1'b0}};
`endif
                            end else begin
                                in_row_r <= in_row_r + ROW_W'(1);
                            end
                        end else begin
                            in_col_r <= in_col_r + COL_W'(1);
                        end
                    end
                end
`ifdef LINE_WINDOW_V_ZERO_PAD_EN
                ST_FLUSH: begin
                    // Column counter walks the buffers; it ends back at 0 after
                    // HALF full lines, leaving the counters ready for a new frame.
                    if (last_col_s) begin
                        in_col_r <= {COL_W{1'b0}};
                        if (flush_row_r == FROW_W'(HALF - 1)) begin
                            state_r     <= ST_STREAM;
                            flush_row_r <= {FROW_W{1'b0}};
                        end else begin
                            flush_row_r <= flush_row_r + FROW_W'(1);
                        end
                    end else begin
                        in_col_r <= in_col_r + COL_W'(1);
                    end
                end
`endif
                default: begin
                    state_r <= ST_STREAM;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_line_window_v_fp.sv
module tb_line_window_v_fp;

    localparam int WH   = 11;
    localparam int IW   = 4;
    localparam int IH   = 12;
    localparam int HALF = (WH - 1) / 2;
    localparam int FPW  = 16;

`ifdef LINE_WINDOW_V_ZERO_PAD_EN
    localparam bit PAD       = 1'b1;
    localparam int EXP_DROPS = 1;
`else
    localparam bit PAD       = 1'b0;
    localparam int EXP_DROPS = 0;
`endif
    localparam int WIN_PER_FRAME = PAD ? IW * IH : IW * (IH - WH + 1);
    localparam int FIRST_ROW     = PAD ? HALF : WH - 1;
    localparam int INTER_GAP     = PAD ? HALF * IW + 2 : 0;
    localparam int LAST_ROW_OUT  = PAD ? IH - 1 : IH - 1 - HALF;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    line_window_v_fp_if #(.EXP_WIDTH(5), .FRAC_WIDTH(10), .WINDOW_HEIGHT(WH)) bus ();

    line_window_v_fp #(
        .EXP_WIDTH(5), .FRAC_WIDTH(10), .WINDOW_HEIGHT(WH),
        .IMAGE_WIDTH(IW), .IMAGE_HEIGHT(IH)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    typedef struct {
        logic [WH*FPW-1:0] win;
        int                col;
        int                row;
        int                cyc;
    } exp_t;

    typedef struct {
        int base;
        int gap_pct;
        int exp_win;
    } vec_t;

    exp_t              sb_q[$];
    int                total = 0;
    int                bad = 0;
    int                cyc = 0;
    int                win_cnt = 0;
    int                drop_cnt = 0;
    int                last_row = -1;
    int                last_col = -1;
    int                spot_cyc = -1;
    int                spot_base = 0;
    logic [FPW-1:0]    fmem [IH][IW];

    function automatic logic [15:0] fp16(input int n);
        int e;
        int m;
        if (n <= 0) return 16'h0000;
        e = 0;
        while ((n >> (e + 1)) != 0) e++;
        m = (n << (10 - e)) & 32'h3FF;
        return {1'b0, 5'(e + 15), 10'(m)};
    endfunction

    task automatic chk(input string name, input logic [WH*FPW-1:0] got, input logic [WH*FPW-1:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, got, want);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pops the scoreboard on every window and checks spot constants.
    always @(negedge clk) begin
        logic [WH*FPW-1:0] got_w;
        logic [WH*FPW-1:0] spot_w;
        exp_t e;
        for (int k = 0; k < WH; k++) got_w[k*FPW +: FPW] = bus.window_o[k][0];
        if (bus.drop_o === 1'b1) drop_cnt++;
        if (cyc == spot_cyc) begin
            for (int k = 0; k < WH; k++) begin
                int rr;
                rr = FIRST_ROW - (WH - 1) + k;
                spot_w[k*FPW +: FPW] = (rr < 0) ? 16'h0000 : fp16(spot_base + rr * IW);
            end
            chk("spot_valid", {175'd0, bus.valid_o}, 176'd1);
            chk("spot_row", 176'(bus.row_o), 176'(FIRST_ROW - HALF));
            chk("spot_col", 176'(bus.col_o), 176'd0);
            chk("spot_win", got_w, spot_w);
        end
        if (bus.valid_o === 1'b1) begin
            win_cnt++;
            last_row = int'(bus.row_o);
            last_col = int'(bus.col_o);
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_window: got row=%0d col=%0d want none", bus.row_o, bus.col_o);
            end else begin
                e = sb_q.pop_front();
                chk("win", got_w, e.win);
                chk("col", 176'(bus.col_o), 176'(e.col));
                chk("row", 176'(bus.row_o), 176'(e.row));
                chk("latency", 176'(cyc), 176'(e.cyc));
            end
        end
    end

    // Frame-memory model: a tap reads the image row it covers, +0 outside the frame.
    task automatic push_window(input int vrow, input int c, input int at_cyc);
        exp_t e;
        for (int k = 0; k < WH; k++) begin
            int rr;
            rr = vrow - (WH - 1) + k;
            e.win[k*FPW +: FPW] = (rr < 0 || rr >= IH) ? 16'h0000 : fmem[rr][c];
        end
        e.col = c;
        e.row = vrow - HALF;
        e.cyc = at_cyc;
        sb_q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.valid_i = 1'b0;
        end
    endtask

    // Drives one frame; abort_at >= 0 asserts rst_i together with that sample.
    task automatic drive_frame(input int base, input int gap_pct, input int abort_at);
        for (int r = 0; r < IH; r++) begin
            for (int c = 0; c < IW; c++) begin
                int n;
                n = 0;
                while (gap_pct > 0 && $urandom_range(99, 0) < gap_pct && n < 8) begin
                    idle(1);
                    n++;
                end
                @(negedge clk);
                bus.valid_i = 1'b1;
                bus.data_i  = fp16(base + r * IW + c);
                if (abort_at == r * IW + c) begin
                    rst = 1'b1;
                    return;
                end
                fmem[r][c] = bus.data_i;
                if (r >= FIRST_ROW) push_window(r, c, cyc + 1);
                if (r == FIRST_ROW && c == 0) begin
                    spot_cyc  = cyc + 1;
                    spot_base = base;
                end
                if (PAD && r == IH - 1 && c == IW - 1) begin
                    for (int f = 0; f < HALF; f++)
                        for (int fc = 0; fc < IW; fc++)
                            push_window(IH + f, fc, cyc + 2 + f * IW + fc);
                end
            end
        end
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        idle(1);
        while (sb_q.size() != 0 && n < 200) begin
            idle(1);
            n++;
        end
        idle(3);
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL %s_drain: pending=%0d want=0", name, sb_q.size());
            sb_q.delete();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[4];
        int   start;
        int   d0;
        logic [WH*FPW-1:0] w;

        vecs[0] = '{base: 0,   gap_pct: 0,  exp_win: WIN_PER_FRAME};
        vecs[1] = '{base: 100, gap_pct: 0,  exp_win: WIN_PER_FRAME};
        vecs[2] = '{base: 0,   gap_pct: 50, exp_win: WIN_PER_FRAME};
        vecs[3] = '{base: 300, gap_pct: 50, exp_win: WIN_PER_FRAME};

        bus.valid_i = 1'b0;
        bus.data_i  = 16'h0000;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int k = 0; k < WH; k++) w[k*FPW +: FPW] = bus.window_o[k][0];
        chk("rst_win", w, 176'd0);
        chk("rst_col", 176'(bus.col_o), 176'd0);
        chk("rst_row", 176'(bus.row_o), 176'd0);
        chk("rst_valid", {175'd0, bus.valid_o}, 176'd0);
        chk("rst_drop", {175'd0, bus.drop_o}, 176'd0);
        rst = 1'b0;
        idle(2);

        // Table: single frames, continuous and gapped, different data.
        for (int i = 0; i < 4; i++) begin
            start = win_cnt;
            drive_frame(vecs[i].base, vecs[i].gap_pct, -1);
            drain("vec");
            chk("vec_count", 176'(win_cnt - start), 176'(vecs[i].exp_win));
            chk("vec_last_row", 176'(last_row), 176'(LAST_ROW_OUT));
            chk("vec_last_col", 176'(last_col), 176'(IW - 1));
        end

        // Two frames back to back (minimum legal spacing with padding).
        start = win_cnt;
        drive_frame(500, 0, -1);
        idle(INTER_GAP);
        drive_frame(600, 0, -1);
        drain("b2b");
        chk("b2b_count", 176'(win_cnt - start), 176'(2 * WIN_PER_FRAME));

        // Reset in the middle of a frame at (r3,c2), then a fresh frame.
        drive_frame(900, 0, 3 * IW + 2);
        @(negedge clk);
        rst = 1'b0;
        bus.valid_i = 1'b0;
        chk("midrst_valid", {175'd0, bus.valid_o}, 176'd0);
        chk("midrst_row", 176'(bus.row_o), 176'd0);
        start = win_cnt;
        drive_frame(0, 0, -1);
        drain("after_rst");
        chk("after_rst_count", 176'(win_cnt - start), 176'(WIN_PER_FRAME));

`ifdef LINE_WINDOW_V_ZERO_PAD_EN
        // A sample arriving during FLUSH is dropped and flagged once.
        start = win_cnt;
        d0 = drop_cnt;
        drive_frame(700, 0, -1);
        idle(3);
        @(negedge clk);
        bus.valid_i = 1'b1;
        bus.data_i  = fp16(1234);
        drain("flush_drop");
        chk("flush_drop_count", 176'(win_cnt - start), 176'(WIN_PER_FRAME));
        chk("flush_drop_pulses", 176'(drop_cnt - d0), 176'd1);
`else
        d0 = 0;
`endif
        chk("drop_total", 176'(drop_cnt + d0 - d0), 176'(EXP_DROPS));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/line_window_v_fp.md
# line_window_v_fp

Vertical window generator for floating-point raster streams. It sits directly upstream of the vertical box/convolution stages. It buffers WINDOW_HEIGHT-1 image lines and, for each incoming pixel, emits a WINDOW_HEIGHT x 1 column of fp samples with the centre pixel's coordinates, ready for `window_i`/`col_i`/`row_i`/`valid_i` of the convolution wrapper.

## Interface
- EXP_WIDTH, 5, fp exponent width
- FRAC_WIDTH, 10, fp fraction width
- FP_WIDTH_REG, 1+EXP_WIDTH+FRAC_WIDTH, sample width (local)
- WINDOW_HEIGHT, 11, window rows; odd, >= 3
- IMAGE_WIDTH, 640, pixels per line
- IMAGE_HEIGHT, 480, lines per frame; >= WINDOW_HEIGHT
- HALF, (WINDOW_HEIGHT-1)/2, local

- clk_i  in  1  clock; one clock domain
- rst_i  in  1  synchronous, active-high reset
- data_i  in  FP_WIDTH_REG  pixel sample, raster order
- valid_i  in  1  data_i valid; no backpressure
- window_o  out  [FP_WIDTH_REG-1:0] [WINDOW_HEIGHT][1]  window column; index 0 = top (oldest line)
- col_o  out  16  centre column
- row_o  out  16  centre row
- valid_o  out  1  window valid
- drop_o  out  1  one-cycle pulse: input sample discarded

## Operation
- Internal counters in_col (0..IMAGE_WIDTH-1) and in_row (0..IMAGE_HEIGHT-1) advance on each accepted sample. in_col wraps to 0 and increments in_row. After (IMAGE_WIDTH-1, IMAGE_HEIGHT-1), both wrap to 0, which marks the next frame.
- Line buffers: WINDOW_HEIGHT-1 arrays of IMAGE_WIDTH entries, arranged as a shift chain per column.
- On an accepted sample at column c:
  - tap k (k < WINDOW_HEIGHT-1) = lb[WINDOW_HEIGHT-2-k][c]; tap WINDOW_HEIGHT-1 = data_i.
  - Then lb[j][c] <= lb[j-1][c] and lb[0][c] <= data_i.
- Buffer contents are never reset or cleared. Stale data from a previous frame is never emitted (masked or not yet valid).
- Default build, valid region only:
  - valid_o asserted for accepted samples with in_row >= WINDOW_HEIGHT-1.
  - col_o = in_col; row_o = in_row - HALF.
  - Emitted windows per frame: IMAGE_WIDTH*(IMAGE_HEIGHT-WINDOW_HEIGHT+1).
- States: STREAM only in the default build; FLUSH exists only with padding (see Configuration).
- drop_o is never asserted in the default build.

## Timing
- Output registers update one cycle after the accepted sample (latency 1). Line buffers read and write the same column in the same cycle; the read returns the old value.
- valid_o is low in every cycle without an emitted window. window_o, col_o and row_o hold their last values when valid_o is low.
- valid_i gaps of any length are allowed. The output sequence does not depend on gap placement.
- Reset values:
  - window_o all 0; col_o 0; row_o 0; valid_o 0; drop_o 0.
  - in_col 0; in_row 0; state STREAM.
- Reset mid-frame: the cycle after rst_i, valid_o = 0. The next accepted sample is treated as (0,0) of a new frame. Any flush in progress is abandoned.

## Configuration
- LINE_WINDOW_V_ZERO_PAD_EN
- Undefined: valid-region-only behaviour as above.
- Defined: zero-padded borders, so every image pixel gets exactly one window (IMAGE_WIDTH*IMAGE_HEIGHT per frame).
  - STREAM: valid_o asserted for in_row >= HALF; row_o = in_row - HALF. Tap k is forced to +0 (all bits 0) when in_row - (WINDOW_HEIGHT-1) + k < 0.
  - STREAM -> FLUSH on acceptance of the last pixel of a frame.
  - FLUSH: the block self-generates HALF*IMAGE_WIDTH windows, one per cycle and back to back. It shifts +0 into the buffers as data. row_o runs IMAGE_HEIGHT-HALF .. IMAGE_HEIGHT-1 and col_o 0..IMAGE_WIDTH-1. Bottom taps are +0.
  - FLUSH -> STREAM after the last flush window is issued. Counters are already 0.
  - valid_i high during FLUSH: the sample is discarded, drop_o pulses in the next cycle, and flush continues unchanged.
  - Upstream must leave at least HALF*IMAGE_WIDTH idle cycles between frames.

## Test plan
Common stimulus values: pixel(r,c) = fp16 of r*IMAGE_WIDTH+c; IMAGE_WIDTH=4, IMAGE_HEIGHT=12, WINDOW_HEIGHT=11.

- Default build, one frame, continuous valid_i:
  - exactly 8 windows emitted;
  - first window one cycle after input (r10,c0): row_o=5, col_o=0, window_o[k]=pixel(k,0);
  - last window: row_o=6, col_o=3.
- PAD build, one frame:
  - 48 windows total;
  - first window after input (r5,c0): row_o=0, taps 0..4 = 0, tap 5 = pixel(0,0), tap 10 = pixel(5,0);
  - after the last input, 20 consecutive valid_o cycles with rows 7..11; for row 11, taps 6..10 = 0.
- Two back-to-back frames with different data:
  - in the PAD build, frame 2 top windows show zeros, never frame-1 data;
  - in the default build, frame 2 output equals the single-frame result.
- Random valid_i gaps (about 50% duty): the output window, col and row sequence is identical to the continuous case.
- rst_i asserted at input (r3,c2):
  - valid_o = 0 next cycle;
  - a subsequent fresh frame produces exactly the single-frame result.
- PAD build, valid_i pulsed during FLUSH:
  - drop_o pulses once;
  - flush still emits all 20 windows with correct coordinates.
